// File: rtl/vram_cpu_port.sv
// CPU-side write/read port for the six-plane RX-78 video RAM.
// Writes fan out to every masked plane; reads fetch one plane byte.
module vram_cpu_port #(
    parameter logic [15:0] BASE   = 16'hEC00,
    parameter logic [15:0] SIZE   = 16'h1400,
    parameter int          PLANES = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rvalid,
    output logic        cpu_wait,
    input  logic        reg_we,
    input  logic        reg_sel,
    input  logic [7:0]  reg_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ
    } state_t;

    localparam logic [16:0] WIN_LO  = {1'b0, BASE};
    localparam logic [16:0] WIN_END = {1'b0, BASE} + {1'b0, SIZE};
    localparam logic [2:0]  NPL     = 3'(PLANES);
    localparam logic [PLANES-1:0] P_ONE = {{(PLANES-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [2:0]        rbank_q, rbank_d;
    logic [PLANES-1:0] wmask_q, wmask_d;
    logic [PLANES-1:0] pend_q, pend_d;
    logic [PLANES-1:0] pend_nx;
    logic [7:0]        rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              wait_q, wait_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [15:0]       addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;

    logic              in_win;
    logic              rd_ok;
    logic [12:0]       acc_off;
    logic              unused_hi;

    // Index of the lowest set bit; plane order on a broadcast write.
    function automatic logic [2:0] lowest(input logic [PLANES-1:0] m);
        logic [2:0] idx;
        idx = '0;
        for (int i = PLANES - 1; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    assign in_win    = ({1'b0, cpu_addr} >= WIN_LO) &&
                       ({1'b0, cpu_addr} < WIN_END);
    assign acc_off   = cpu_addr[12:0] - BASE[12:0];
    assign rd_ok     = (rbank_q != 3'd0) && (rbank_q <= NPL);
    assign pend_nx   = pend_q & (pend_q - P_ONE);
    assign unused_hi = ^reg_wdata[7:PLANES];

    always_comb begin
        state_d  = state_q;
        rbank_d  = rbank_q;
        wmask_d  = wmask_q;
        pend_d   = pend_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;

        if (reg_we) begin
            if (reg_sel) wmask_d = reg_wdata[PLANES-1:0];
            else         rbank_d = reg_wdata[2:0];
        end

        unique case (state_q)
            S_IDLE: begin
                if (cpu_req && in_win) begin
                    if (cpu_we) begin
                        if (wmask_q != '0) begin
                            state_d = S_WRITE;
                            pend_d  = wmask_q;
                            req_d   = 1'b1;
                            we_d    = 1'b1;
                            addr_d  = {lowest(wmask_q), acc_off};
                            wdata_d = cpu_wdata;
                        end
                    end else if (rd_ok) begin
                        state_d = S_READ;
                        req_d   = 1'b1;
                        we_d    = 1'b0;
                        addr_d  = {rbank_q - 3'd1, acc_off};
                    end else begin
                        // Unmapped bank reads back as open bus.
                        rdata_d  = 8'hFF;
                        rvalid_d = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (mem_ack) begin
                    pend_d = pend_nx;
                    if (pend_nx != '0) begin
                        addr_d = {lowest(pend_nx), addr_q[12:0]};
                    end else begin
                        state_d = S_IDLE;
                        req_d   = 1'b0;
                        we_d    = 1'b0;
                    end
                end
            end
            S_READ: begin
                if (mem_ack) begin
                    state_d  = S_IDLE;
                    rdata_d  = mem_rdata;
                    rvalid_d = 1'b1;
                    req_d    = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase

        wait_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            rbank_q  <= '0;
            wmask_q  <= '0;
            pend_q   <= '0;
            rdata_q  <= 8'h00;
            rvalid_q <= 1'b0;
            wait_q   <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rbank_q  <= rbank_d;
            wmask_q  <= wmask_d;
            pend_q   <= pend_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            wait_q   <= wait_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign cpu_rdata  = rdata_q;
    assign cpu_rvalid = rvalid_q;
    assign cpu_wait   = wait_q;
    assign mem_req    = req_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

endmodule
